// File: rtl/im_port_arbiter.sv
// Single-port instruction-memory arbiter: CPU fetch (read-only) vs. program loader (read/write).
// Optional exclusive loader lock is compiled in with `define IM_ARB_LOCK_EN.
module im_port_arbiter #(
   parameter int AW         = 11,
   parameter int DW         = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic          if_gnt,
   output logic          if_rvalid,
   output logic [DW-1:0] if_rdata,
   input  logic          ld_req,
   input  logic          ld_we,
   input  logic [AW-1:0] ld_addr,
   input  logic [DW-1:0] ld_wdata,
   input  logic          ld_lock,
   output logic          ld_gnt,
   output logic          ld_rvalid,
   output logic [DW-1:0] ld_rdata,
   output logic          bram_en,
   output logic          bram_we,
   output logic [AW-1:0] bram_addr,
   output logic [DW-1:0] bram_wdata,
   input  logic [DW-1:0] bram_rdata
);

   localparam logic [0:0] S_SHARE = 1'b0;
   localparam logic [0:0] S_LOCK  = 1'b1;
   localparam logic [3:0] SMAX    = 4'(STARVE_MAX);

   logic [0:0] state;
   logic [3:0] starve_cnt;
   logic       rd_pend;
   logic       rd_owner_ld;
   logic       locked;

`ifdef IM_ARB_LOCK_EN
   // Lock takes effect in the cycle ld_lock is high so the fetch side never sneaks in.
   assign locked = ld_lock;
`else
   logic unused_lock;
   assign unused_lock = ld_lock;
   assign locked      = 1'b0;
`endif

   always_comb begin
      if_gnt = 1'b0;
      ld_gnt = 1'b0;
      if (locked) begin
         ld_gnt = ld_req;
      end else if (if_req && ld_req) begin
         if (starve_cnt < SMAX) if_gnt = 1'b1;
         else                   ld_gnt = 1'b1;
      end else begin
         if_gnt = if_req;
         ld_gnt = ld_req;
      end
   end

   assign bram_en    = if_gnt | ld_gnt;
   assign bram_we    = ld_gnt & ld_we;
   assign bram_addr  = ld_gnt ? ld_addr : if_addr;
   assign bram_wdata = ld_wdata;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_SHARE;
      end else begin
         state <= locked ? S_LOCK : S_SHARE;
      end
   end

   // Counts consecutive contested fetch wins; any other cycle clears it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve_cnt <= '0;
      end else if (locked || state == S_LOCK) begin
         starve_cnt <= '0;
      end else if (if_req && ld_req && if_gnt) begin
         if (starve_cnt != 4'hF) starve_cnt <= starve_cnt + 4'd1;
      end else begin
         starve_cnt <= '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_pend     <= 1'b0;
         rd_owner_ld <= 1'b0;
      end else begin
         rd_pend     <= if_gnt | (ld_gnt & ~ld_we);
         rd_owner_ld <= ld_gnt & ~ld_we;
      end
   end

   assign if_rvalid = rd_pend & ~rd_owner_ld;
   assign ld_rvalid = rd_pend & rd_owner_ld;
   assign if_rdata  = bram_rdata;
   assign ld_rdata  = bram_rdata;

endmodule

// File: tb/tb_im_port_arbiter.sv
// Bench for im_port_arbiter: BRAM model, reference arbiter model and read-data scoreboard.
module tb_im_port_arbiter;
   localparam int AW = 11;
   localparam int DW = 32;
   localparam int SM = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          if_req, ld_req, ld_we, ld_lock;
   logic [AW-1:0] if_addr, ld_addr;
   logic [DW-1:0] ld_wdata;
   logic          if_gnt, if_rvalid, ld_gnt, ld_rvalid;
   logic [DW-1:0] if_rdata, ld_rdata;
   logic          bram_en, bram_we;
   logic [AW-1:0] bram_addr;
   logic [DW-1:0] bram_wdata, bram_rdata;

   typedef struct {
      logic          ld;
      logic [DW-1:0] data;
   } sb_t;

   sb_t           sbq[$];
   logic [DW-1:0] mem [2**AW];
   logic [DW-1:0] sh  [2**AW];
   int            m_cnt;
   int            n_chk  = 0;
   int            n_fail = 0;
   logic [15:0]   ld_hist = '0;
   logic [15:0]   if_hist = '0;

   im_port_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(SM)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
      .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
      .ld_lock(ld_lock), .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
      .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
      .bram_wdata(bram_wdata), .bram_rdata(bram_rdata)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   initial begin
      for (int i = 0; i < 2**AW; i++) begin
         mem[i] = 32'hC0DE_0000 ^ i;
         sh[i]  = 32'hC0DE_0000 ^ i;
      end
   end

   always @(posedge clk) begin
      if (bram_en) begin
         if (bram_we) mem[bram_addr] <= bram_wdata;
         else         bram_rdata     <= mem[bram_addr];
      end
   end

   // Reference model and scoreboard, sampled on the falling edge.
   always @(negedge clk) begin
      sb_t  e;
      logic ex_ifrv, ex_ldrv, ex_if, ex_ld, lk;
      if (!rst_n) begin
         sbq.delete();
         m_cnt = 0;
         chk("rst_if_rvalid", if_rvalid, 0);
         chk("rst_ld_rvalid", ld_rvalid, 0);
      end else begin
         ex_ifrv = 0;
         ex_ldrv = 0;
         e.ld = 0; e.data = '0;
         if (sbq.size() > 0) begin
            e = sbq.pop_front();
            if (e.ld) ex_ldrv = 1; else ex_ifrv = 1;
         end
         chk("if_rvalid", if_rvalid, ex_ifrv);
         chk("ld_rvalid", ld_rvalid, ex_ldrv);
         if (ex_ifrv) chk("if_rdata", if_rdata, e.data);
         if (ex_ldrv) chk("ld_rdata", ld_rdata, e.data);
`ifdef IM_ARB_LOCK_EN
         lk = ld_lock;
`else
         lk = 0;
`endif
         ex_ld = ld_req && (lk || !if_req || m_cnt >= SM);
         ex_if = if_req && !lk && !ex_ld;
         chk("if_gnt", if_gnt, ex_if);
         chk("ld_gnt", ld_gnt, ex_ld);
         chk("bram_en", bram_en, ex_if | ex_ld);
         if (ex_if) begin
            chk("bram_addr_if", bram_addr, if_addr);
            chk("bram_we_if", bram_we, 0);
            sbq.push_back('{ld: 1'b0, data: sh[if_addr]});
         end
         if (ex_ld) begin
            chk("bram_addr_ld", bram_addr, ld_addr);
            chk("bram_we_ld", bram_we, ld_we);
            if (ld_we) begin
               chk("bram_wdata", bram_wdata, ld_wdata);
               sh[ld_addr] = ld_wdata;
            end else begin
               sbq.push_back('{ld: 1'b1, data: sh[ld_addr]});
            end
         end
         if (bram_en) chk("bram_addr_known", $isunknown(bram_addr), 0);
         if (lk) m_cnt = 0;
         else if (if_req && ld_req) m_cnt = ex_if ? m_cnt + 1 : 0;
         else m_cnt = 0;
         ld_hist = {ld_hist[14:0], ld_gnt};
         if_hist = {if_hist[14:0], if_gnt};
      end
   end

   task automatic cyc(input logic ir, input logic [AW-1:0] ia, input logic lr, input logic we,
                      input logic [AW-1:0] la, input logic [DW-1:0] wd, input logic lk);
      if_req = ir; if_addr = ia;
      ld_req = lr; ld_we = we; ld_addr = la; ld_wdata = wd; ld_lock = lk;
      @(posedge clk); #1;
   endtask

   task automatic idle();
      cyc(0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      rst_n = 0;
      if_req = 0; if_addr = '0; ld_req = 0; ld_we = 0; ld_addr = '0; ld_wdata = '0; ld_lock = 0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1;
      idle();

      // fetch-only streak
      for (int i = 0; i < 4; i++) cyc(1, AW'(i), 0, 0, 0, 0, 0);
      idle();

      // loader write then fetch of the same word
      cyc(0, 0, 1, 1, 11'h004, 32'hDEADBEEF, 0);
      cyc(1, 11'h004, 0, 0, 0, 0, 0);
      idle(); idle();

      // both held 15 cycles: F,F,F,F,L x3
      if_req = 1; if_addr = 11'h020; ld_req = 1; ld_we = 0; ld_addr = 11'h010; ld_lock = 0;
      repeat (15) @(posedge clk);
      #1;
      chk("starve_pattern", ld_hist[14:0], 15'b000010000100001);
      idle(); idle();

      // reset in the cycle after a fetch read grant, with the counter non-zero
      for (int i = 0; i < 3; i++) cyc(1, 11'h030, 1, 0, 11'h031, 0, 0);
      if_req = 0; ld_req = 0; rst_n = 0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1;
      idle();
      cyc(1, 11'h032, 0, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) cyc(1, 11'h033, 1, 0, 11'h034, 0, 0);
      chk("post_rst_pattern", ld_hist[4:0], 5'b00001);
      idle(); idle();

      // lock window with fetch held
      cyc(1, 11'h040, 0, 0, 0, 0, 0);
      for (int i = 0; i < 8; i++) cyc(1, 11'h041, 1, 1, AW'(11'h100 + i), 32'h1000 + i, 1);
`ifdef IM_ARB_LOCK_EN
      chk("lock_if_gnt", if_hist[7:0], 8'h00);
      chk("lock_ld_gnt", ld_hist[7:0], 8'hFF);
`endif
      cyc(1, 11'h041, 0, 0, 0, 0, 0);
      chk("unlock_if_gnt", if_hist[0], 1);
      idle();
      for (int i = 0; i < 8; i++) cyc(0, 0, 1, 0, AW'(11'h100 + i), 0, 0);
      idle(); idle();

      // address wrap
      cyc(1, 11'h7FF, 0, 0, 0, 0, 0);
      cyc(1, 11'h000, 0, 0, 0, 0, 0);
      chk("wrap_gnts", if_hist[1:0], 2'b11);
      idle(); idle();

      chk("sb_empty", sbq.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
